// File: rtl/cpu_run_ctrl.sv
// Run controller for the CPU cores: sequences the core reset, gates core
// execution, counts cycles and retired instructions, drains the pipeline
// after halt and enforces an optional cycle budget.
//
// Handshake: there is no valid/ready pair here. start is a single-cycle
// pulse sampled only in IDLE, DONE and TIMEOUT_ST. halt and retire are
// level inputs sampled on every rising clock edge. done is a sticky
// completion flag that stays high until the next run starts or reset.
module cpu_run_ctrl #(
  parameter int RESET_CYCLES = 4,
  parameter int DRAIN_CYCLES = 5,
  parameter int MAX_CYCLES   = 40,
  parameter int CNT_W        = 32,
  parameter int AUTO_START   = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             halt,
  input  logic             retire,
  output logic             core_reset,
  output logic             run_en,
  output logic             done,
  output logic             timeout,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] retire_count,
  output logic [2:0]       state
);

  // The hold counter serves both the reset hold and the drain phase.
  localparam int HW = 16;
  localparam logic [CNT_W-1:0] CNT_SAT = '1;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    RST_HOLD   = 3'd1,
    RUN        = 3'd2,
    DRAIN      = 3'd3,
    DONE       = 3'd4,
    TIMEOUT_ST = 3'd5
  } state_t;

  state_t           st_q, st_d;
  logic [HW-1:0]    hold_q, hold_d;
  logic [CNT_W-1:0] cyc_d, ret_d;
  logic [CNT_W-1:0] cyc_inc, ret_inc;
  logic             budget_hit;

  assign state = st_q;

  // Saturating increments and the budget comparison on the incremented count.
  always_comb begin
    cyc_inc    = (cycle_count == CNT_SAT) ? cycle_count : cycle_count + CNT_W'(1);
    ret_inc    = (retire_count == CNT_SAT) ? retire_count : retire_count + CNT_W'(1);
    budget_hit = (MAX_CYCLES != 0) && (64'(cyc_inc) == 64'(MAX_CYCLES));
  end

  // Next-state, hold counter and count update logic.
  always_comb begin
    st_d   = st_q;
    hold_d = hold_q;
    cyc_d  = cycle_count;
    ret_d  = retire_count;
    case (st_q)
      IDLE: begin
        if ((AUTO_START != 0) || start) begin
          st_d   = RST_HOLD;
          hold_d = HW'(RESET_CYCLES - 1);
          cyc_d  = '0;
          ret_d  = '0;
        end
      end
      RST_HOLD: begin
        if (hold_q == '0) begin
          st_d = RUN;
        end else begin
          hold_d = hold_q - HW'(1);
        end
      end
      RUN: begin
        cyc_d = cyc_inc;
        if (retire) begin
          ret_d = ret_inc;
        end
        // halt has priority over a budget hit in the same cycle
        if (halt) begin
          if (DRAIN_CYCLES == 0) begin
            st_d = DONE;
          end else begin
            st_d   = DRAIN;
            hold_d = HW'(DRAIN_CYCLES - 1);
          end
        end else if (budget_hit) begin
          st_d = TIMEOUT_ST;
        end
      end
      DRAIN: begin
        cyc_d = cyc_inc;
        if (retire) begin
          ret_d = ret_inc;
        end
        if (hold_q == '0) begin
          st_d = DONE;
        end else begin
          hold_d = hold_q - HW'(1);
        end
      end
      DONE, TIMEOUT_ST: begin
        if (start) begin
          st_d   = RST_HOLD;
          hold_d = HW'(RESET_CYCLES - 1);
          cyc_d  = '0;
          ret_d  = '0;
        end
      end
      default: begin
        st_d = IDLE;
      end
    endcase
  end

  // State, counters and outputs registered together; outputs decode the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q         <= IDLE;
      hold_q       <= '0;
      cycle_count  <= '0;
      retire_count <= '0;
      core_reset   <= 1'b1;
      run_en       <= 1'b0;
      done         <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      st_q         <= st_d;
      hold_q       <= hold_d;
      cycle_count  <= cyc_d;
      retire_count <= ret_d;
      core_reset   <= (st_d == IDLE) || (st_d == RST_HOLD);
      run_en       <= (st_d == RUN) || (st_d == DRAIN);
      done         <= (st_d == DONE) || (st_d == TIMEOUT_ST);
      timeout      <= (st_d == TIMEOUT_ST);
    end
  end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Testbench for cpu_run_ctrl: three instances with different parameter sets,
// each with its own reset so they can be exercised one at a time.
module tb_cpu_run_ctrl;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst[3];
  logic start[3];
  logic halt[3];
  logic retire[3];

  logic        cr_a, re_a, dn_a, to_a;
  logic [2:0]  st_a;
  logic [31:0] cyc_a, ret_a;
  logic        cr_b, re_b, dn_b, to_b;
  logic [2:0]  st_b;
  logic [31:0] cyc_b, ret_b;
  logic        cr_c, re_c, dn_c, to_c;
  logic [2:0]  st_c;
  logic [3:0]  cyc_c, ret_c;

  logic        cr[3], re[3], dn[3], tmo[3];
  logic [2:0]  st[3];
  logic [31:0] cyc[3], ret[3];

  assign cr[0] = cr_a;  assign re[0] = re_a;  assign dn[0] = dn_a;  assign tmo[0] = to_a;
  assign st[0] = st_a;  assign cyc[0] = cyc_a; assign ret[0] = ret_a;
  assign cr[1] = cr_b;  assign re[1] = re_b;  assign dn[1] = dn_b;  assign tmo[1] = to_b;
  assign st[1] = st_b;  assign cyc[1] = cyc_b; assign ret[1] = ret_b;
  assign cr[2] = cr_c;  assign re[2] = re_c;  assign dn[2] = dn_c;  assign tmo[2] = to_c;
  assign st[2] = st_c;  assign cyc[2] = {28'd0, cyc_c}; assign ret[2] = {28'd0, ret_c};

  // Default parameters
  cpu_run_ctrl u_a (
    .clk(clk), .reset(rst[0]), .start(start[0]), .halt(halt[0]), .retire(retire[0]),
    .core_reset(cr_a), .run_en(re_a), .done(dn_a), .timeout(to_a),
    .cycle_count(cyc_a), .retire_count(ret_a), .state(st_a)
  );

  // No drain, short budget, manual start
  cpu_run_ctrl #(.DRAIN_CYCLES(0), .MAX_CYCLES(10), .AUTO_START(0)) u_b (
    .clk(clk), .reset(rst[1]), .start(start[1]), .halt(halt[1]), .retire(retire[1]),
    .core_reset(cr_b), .run_en(re_b), .done(dn_b), .timeout(to_b),
    .cycle_count(cyc_b), .retire_count(ret_b), .state(st_b)
  );

  // Narrow counters, budget disabled
  cpu_run_ctrl #(.CNT_W(4), .MAX_CYCLES(0)) u_c (
    .clk(clk), .reset(rst[2]), .start(start[2]), .halt(halt[2]), .retire(retire[2]),
    .core_reset(cr_c), .run_en(re_c), .done(dn_c), .timeout(to_c),
    .cycle_count(cyc_c), .retire_count(ret_c), .state(st_c)
  );

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [70:0] exp_q0[$];
  logic [70:0] exp_q1[$];
  logic [70:0] exp_q2[$];

  // Observation record: {state, done, timeout, run_en, core_reset, cycles, retires}
  function automatic logic [70:0] mk(input logic [2:0] s, input logic d, input logic t,
                                     input logic r, input logic c,
                                     input logic [31:0] cy, input logic [31:0] rt);
    return {s, d, t, r, c, cy, rt};
  endfunction

  function automatic logic [70:0] obs(input int d);
    return {st[d], dn[d], tmo[d], re[d], cr[d], cyc[d], ret[d]};
  endfunction

  task automatic check(input string name, input logic [70:0] act, input logic [70:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    end
  endtask

  // Monitor: each rising edge of done consumes one expected completion record.
  logic dprev[3];
  always @(negedge clk) begin
    logic [70:0] e;
    logic        got;
    for (int d = 0; d < 3; d++) begin
      if (dn[d] && !dprev[d]) begin
        got = 1'b0;
        e   = '0;
        case (d)
          0: if (exp_q0.size() > 0) begin e = exp_q0.pop_front(); got = 1'b1; end
          1: if (exp_q1.size() > 0) begin e = exp_q1.pop_front(); got = 1'b1; end
          default: if (exp_q2.size() > 0) begin e = exp_q2.pop_front(); got = 1'b1; end
        endcase
        if (got) begin
          check($sformatf("done_rec_dut%0d", d), obs(d), e);
        end else begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_done_dut%0d: got %0h expected no completion", d, obs(d));
        end
      end
      dprev[d] <= dn[d];
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  // Counts RST_HOLD cycles until RUN is seen, then checks RUN entry outputs.
  task automatic hold_len(input int d, input int exp_n);
    int n = 0;
    int k = 0;
    while (st[d] !== 3'd2 && k < 40) begin
      if (st[d] === 3'd1) n++;
      tick();
      k++;
    end
    check($sformatf("hold_len_dut%0d", d), 71'(n), 71'(exp_n));
    check($sformatf("run_entry_dut%0d", d), {69'd0, re[d], cr[d]}, 71'b10);
  endtask

  task automatic wait_done(input int d, input int budget);
    int k = 0;
    while (!dn[d] && k < budget) begin
      tick();
      k++;
    end
    check($sformatf("done_seen_dut%0d", d), {70'd0, dn[d]}, 71'd1);
  endtask

  task automatic pulse_start(input int d);
    start[d] = 1'b1;
    tick();
    start[d] = 1'b0;
  endtask

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  logic [70:0] rst_obs;

  initial begin
    rst_obs = mk(3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0);
    for (int d = 0; d < 3; d++) begin
      rst[d] = 1'b1; start[d] = 1'b0; halt[d] = 1'b0; retire[d] = 1'b0;
    end
    repeat (2) tick();
    for (int d = 0; d < 3; d++) check($sformatf("reset_dut%0d", d), obs(d), rst_obs);

    // --- DUT A: timeout run with retire every cycle
    retire[0] = 1'b1;
    rst[0] = 1'b0;
    hold_len(0, 4);
    exp_q0.push_back(mk(3'd5, 1'b1, 1'b1, 1'b0, 1'b0, 32'd40, 32'd40));
    wait_done(0, 60);
    tick();

    // --- DUT A: restart, halt on 10th RUN cycle, 5-cycle drain
    pulse_start(0);
    check("restart_clear_a", obs(0), mk(3'd1, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0));
    hold_len(0, 4);
    exp_q0.push_back(mk(3'd4, 1'b1, 1'b0, 1'b0, 1'b0, 32'd15, 32'd15));
    repeat (9) tick();
    halt[0] = 1'b1;
    tick();
    halt[0] = 1'b0;
    check("drain_entry_a", obs(0), mk(3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 32'd10, 32'd10));
    wait_done(0, 20);
    repeat (2) tick();
    check("frozen_a", obs(0), mk(3'd4, 1'b1, 1'b0, 1'b0, 1'b0, 32'd15, 32'd15));

    // --- DUT A: asynchronous reset in the middle of DRAIN
    retire[0] = 1'b0;
    pulse_start(0);
    hold_len(0, 4);
    repeat (9) tick();
    halt[0] = 1'b1;
    tick();
    halt[0] = 1'b0;
    check("in_drain_a", {68'd0, st[0]}, 71'd3);
    #2 rst[0] = 1'b1;
    #1 check("async_reset_a", obs(0), rst_obs);
    tick();
    rst[0] = 1'b0;
    hold_len(0, 4);
    exp_q0.push_back(mk(3'd5, 1'b1, 1'b1, 1'b0, 1'b0, 32'd40, 32'd0));
    wait_done(0, 60);

    // --- DUT B: manual start; halt and budget in the same cycle
    rst[1] = 1'b0;
    halt[1] = 1'b1;
    retire[1] = 1'b1;
    repeat (3) tick();
    check("idle_ignores_inputs_b", obs(1), rst_obs);
    halt[1] = 1'b0;
    retire[1] = 1'b0;
    repeat (2) tick();
    check("idle_no_start_b", obs(1), rst_obs);
    pulse_start(1);
    hold_len(1, 4);
    exp_q1.push_back(mk(3'd4, 1'b1, 1'b0, 1'b0, 1'b0, 32'd10, 32'd4));
    retire[1] = 1'b1;            // RUN cycles 1..3
    repeat (3) tick();
    retire[1] = 1'b0;            // RUN cycles 4..9
    repeat (6) tick();
    retire[1] = 1'b1;            // RUN cycle 10, with halt
    halt[1] = 1'b1;
    tick();
    halt[1] = 1'b0;              // retire still high in first DONE cycle
    wait_done(1, 5);
    tick();
    check("frozen_b", obs(1), mk(3'd4, 1'b1, 1'b0, 1'b0, 1'b0, 32'd10, 32'd4));
    pulse_start(1);
    check("restart_clear_b", obs(1), mk(3'd1, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0));
    hold_len(1, 4);
    exp_q1.push_back(mk(3'd5, 1'b1, 1'b1, 1'b0, 1'b0, 32'd10, 32'd10));
    wait_done(1, 20);

    // --- DUT C: narrow counters saturate, no budget
    retire[2] = 1'b1;
    rst[2] = 1'b0;
    hold_len(2, 4);
    repeat (20) tick();
    check("saturate_c", obs(2), mk(3'd2, 1'b0, 1'b0, 1'b1, 1'b0, 32'd15, 32'd15));
    exp_q2.push_back(mk(3'd4, 1'b1, 1'b0, 1'b0, 1'b0, 32'd15, 32'd15));
    halt[2] = 1'b1;
    tick();
    halt[2] = 1'b0;
    wait_done(2, 20);
    tick();

    // ---------------- report ----------------
    check("queue_empty_a", 71'(exp_q0.size()), 71'd0);
    check("queue_empty_b", 71'(exp_q1.size()), 71'd0);
    check("queue_empty_c", 71'(exp_q2.size()), 71'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cpu_run_ctrl.md
Name: cpu_run_ctrl

Overview:
Synthesizable run controller for the single-cycle and pipelined CPU cores. It sequences the core reset, gates core execution and counts cycles and retired instructions. It detects halt, drains the pipeline and applies a cycle-budget timeout. It sits between the top-level clock/reset and the CPU core. It replaces the fixed reset-pulse and fixed cycle-count sequencing with a parametrised, restartable state machine.

Parameters:
RESET_CYCLES, 4, cycles core_reset is held after a start (minimum 1)
DRAIN_CYCLES, 5, cycles run_en stays high after halt so in-flight instructions complete (0 = no drain)
MAX_CYCLES, 40, cycle budget before timeout (0 = timeout disabled)
CNT_W, 32, width of cycle_count and retire_count
AUTO_START, 1, 1 = start a run automatically on reset release; 0 = wait for start

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  single-cycle pulse; begins or restarts a run when in IDLE, DONE or TIMEOUT_ST
halt  input  1  core halt indication (halt instruction reached)
retire  input  1  one instruction retired this cycle
core_reset  output  1  synchronous reset to the CPU core
run_en  output  1  core clock-enable/stall release
done  output  1  run finished, by halt or by timeout; sticky
timeout  output  1  run ended on cycle budget; sticky
cycle_count  output  CNT_W  cycles spent in RUN and DRAIN
retire_count  output  CNT_W  retire pulses counted in RUN and DRAIN
state  output  3  IDLE=0, RST_HOLD=1, RUN=2, DRAIN=3, DONE=4, TIMEOUT_ST=5

Behaviour:
- Reset asserted (asynchronous) puts the block in IDLE. Outputs: core_reset=1, run_en=0, done=0, timeout=0, both counts=0, internal hold/drain counter=0.
- All outputs are registered and decoded from state. There is no combinational path from any input to any output.
- IDLE:
  - core_reset=1.
  - If AUTO_START=1, go to RST_HOLD on the first clock after reset release.
  - Otherwise go to RST_HOLD on start=1.
  - halt and retire are ignored.
- RST_HOLD:
  - Entry loads the hold counter with RESET_CYCLES-1. Entry clears both counts, done and timeout.
  - core_reset=1 and run_en=0 for exactly RESET_CYCLES cycles, then go to RUN.
- RUN:
  - core_reset=0, run_en=1.
  - cycle_count increments every cycle. retire_count increments when retire=1. Both saturate at all-ones (no wrap).
  - halt=1: go to DRAIN with the counter loaded to DRAIN_CYCLES-1. If DRAIN_CYCLES=0, go directly to DONE.
  - MAX_CYCLES!=0 and the incremented cycle_count equals MAX_CYCLES: go to TIMEOUT_ST.
  - halt and the timeout condition in the same cycle: halt wins (DRAIN or DONE), timeout stays 0.
- DRAIN:
  - run_en=1. Counts continue incrementing.
  - The timeout check is suspended.
  - Further halt pulses are ignored.
  - After DRAIN_CYCLES cycles, go to DONE.
- DONE:
  - run_en=0, core_reset=0 so core state stays inspectable, done=1.
  - Counts are frozen.
- TIMEOUT_ST:
  - run_en=0, done=1, timeout=1.
  - Counts are frozen.
- start in DONE or TIMEOUT_ST: go to RST_HOLD (restart). The clears take effect on RST_HOLD entry.
- start in RST_HOLD, RUN or DRAIN: ignored.
- Reset asserted mid-run (any state): immediate return to IDLE with reset values. If AUTO_START=1, a new run begins on reset release.
- retire coincident with the halt cycle: counted. retire in the first cycle of DONE: not counted.
- Illegal state encodings (6, 7) go to IDLE on the next clock.

Test Plan:
- Defaults, reset high 5 ns then low: core_reset=1 for exactly 4 cycles, then run_en=1. halt never asserted, retire every cycle → TIMEOUT_ST after 40 RUN cycles, done=1, timeout=1, cycle_count=40, retire_count=40.
- Defaults, halt pulsed on the 10th RUN cycle, retire every cycle → DRAIN for 5 cycles, DONE with cycle_count=15, retire_count=15, timeout=0, run_en=0.
- DRAIN_CYCLES=0, MAX_CYCLES=10, halt asserted on the 10th RUN cycle (same cycle as budget hit) → DONE, timeout=0, cycle_count=10.
- AUTO_START=0: no activity while start=0 (state=0, counts 0). start pulse → RST_HOLD 4 cycles → RUN. After DONE, a second start → counts clear to 0 on RST_HOLD entry, full new run.
- Reset asserted asynchronously mid-DRAIN (between clock edges) → outputs return to reset values immediately. On release the run re-sequences from RST_HOLD.
- CNT_W=4, MAX_CYCLES=0, retire every cycle for 20 RUN cycles → cycle_count and retire_count saturate at 15, no timeout. halt then gives DONE.
